// File: rtl/cpu_pkg.sv
// Shared decode definitions for the integer pipeline.
// Opcodes, field positions and the decoded-instruction bundle.
package cpu_pkg;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int FN_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic        uses_rs;
    logic        uses_rt;
    logic        wen;
  } dec_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    DEC   = 2'b01,
    OUT   = 2'b10,
    BOTH  = 2'b11
  } of_state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational field split and class decode.
// Unknown opcodes decode as nops with no register use.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [5:0]  w_op;
  logic [4:0]  w_rd;
  logic [15:0] w_imm16;
  logic        w_zext;

  assign w_op    = i_instr[OP_LSB +: 6];
  assign w_rd    = i_instr[RD_LSB +: 5];
  assign w_imm16 = i_instr[15:0];
  assign w_zext  = (w_op == OP_ANDI) |
                   (w_op == OP_ORI)  |
                   (w_op == OP_XORI);

  always_comb begin
    o_dec       = '0;
    o_dec.op    = w_op;
    o_dec.funct = i_instr[FN_LSB +: 6];
    o_dec.rs    = i_instr[RS_LSB +: 5];
    o_dec.rt    = i_instr[RT_LSB +: 5];
    o_dec.imm   = w_zext ? {16'h0, w_imm16}
                         : {{16{w_imm16[15]}}, w_imm16};
    unique case (1'b1)
      (w_op == OP_RTYPE): begin
        o_dec.uses_rs = 1'b1;
        o_dec.uses_rt = 1'b1;
        o_dec.wen     = 1'b1;
        o_dec.dest    = w_rd;
      end
      (w_op[5:3] == 3'b001),
      (w_op == OP_LW): begin
        o_dec.uses_rs = 1'b1;
        o_dec.wen     = 1'b1;
        o_dec.dest    = i_instr[RT_LSB +: 5];
      end
      (w_op == OP_SW),
      (w_op == OP_BEQ),
      (w_op == OP_BNE): begin
        o_dec.uses_rs = 1'b1;
        o_dec.uses_rt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: two-slot skid, scoreboard,
// RAW stall and writeback bypass ahead of execute.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [AW-1:0]   rf_addr1,
  output logic [AW-1:0]   rf_addr2,
  input  logic [XLEN-1:0] rf_out1,
  input  logic [XLEN-1:0] rf_out2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_op,
  output logic [5:0]      out_funct,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_dest,
  output logic            out_wen
);

  of_state_t       r_state, w_state_nxt;
  dec_t            r_dec, w_dec_in;
  logic [NREG-1:0] r_pend, w_pend_nxt;

  logic [5:0]      r_op, r_funct;
  logic [XLEN-1:0] r_a, r_b, r_imm;
  logic [AW-1:0]   r_dest;
  logic            r_wen;

  logic w_dec_v, w_out_v;
  logic w_byp1, w_byp2, w_haz;
  logic w_adv, w_acc;
  logic w_dec_nxt, w_out_nxt;

  instr_decode u_dec (
    .i_instr (in_instr),
    .o_dec   (w_dec_in)
  );

  assign w_dec_v = r_state[0];
  assign w_out_v = r_state[1];

  assign w_byp1 = wb_valid && (wb_addr == r_dec.rs);
  assign w_byp2 = wb_valid && (wb_addr == r_dec.rt);

  // A writeback landing this cycle resolves the hazard via bypass.
  assign w_haz =
    (r_dec.uses_rs & r_pend[r_dec.rs] & ~w_byp1) |
    (r_dec.uses_rt & r_pend[r_dec.rt] & ~w_byp2);

  assign w_adv = w_dec_v & ~w_haz & (~w_out_v | out_ready);
  assign in_ready = ~w_dec_v | w_adv;
  assign w_acc = in_valid & in_ready;

  assign rf_addr1 = w_dec_v ? r_dec.rs : '0;
  assign rf_addr2 = w_dec_v ? r_dec.rt : '0;

  always_comb begin
    w_dec_nxt = w_dec_v;
    w_out_nxt = w_out_v;
    if (w_acc)
      w_dec_nxt = 1'b1;
    else if (w_adv)
      w_dec_nxt = 1'b0;
    if (w_adv)
      w_out_nxt = 1'b1;
    else if (out_ready & w_out_v)
      w_out_nxt = 1'b0;
    w_state_nxt = of_state_t'({w_out_nxt, w_dec_nxt});
  end

  // Set after clear so an issuing writer wins over a retiring one.
  always_comb begin
    w_pend_nxt = r_pend;
    if (wb_valid)
      w_pend_nxt[wb_addr] = 1'b0;
    if (w_adv & r_dec.wen)
      w_pend_nxt[r_dec.dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_pend  <= '0;
      r_dec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_acc)
        r_dec <= w_dec_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_funct <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_dest  <= '0;
      r_wen   <= 1'b0;
    end else if (w_adv) begin
      r_op    <= r_dec.op;
      r_funct <= r_dec.funct;
      r_a     <= w_byp1 ? wb_data : rf_out1;
      r_b     <= w_byp2 ? wb_data : rf_out2;
      r_imm   <= r_dec.imm;
      r_dest  <= r_dec.dest;
      r_wen   <= r_dec.wen;
    end
  end

  assign out_valid = w_out_v;
  assign out_op    = r_op;
  assign out_funct = r_funct;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_imm   = r_imm;
  assign out_dest  = r_dest;
  assign out_wen   = r_wen;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch stage sitting directly upstream of the 32x32 register file, and between instruction fetch and execute.
- Accepts 32-bit MIPS-style instructions over valid/ready, decodes fields, and drives register-file read addresses. Captures both read operands and immediate into an output register for execute.
- Holds a 32-bit scoreboard of pending writebacks and stalls on RAW hazards, with bypass from the writeback port.

Parameters:
- XLEN, 32, datapath width
- NREG, 32, register count (scoreboard width)
- AW, 5, register address width

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept an instruction this cycle
- in_instr  in  32  instruction word
- rf_addr1  out  AW  register-file read address 1 (rs)
- rf_addr2  out  AW  register-file read address 2 (rt)
- rf_out1  in  XLEN  register-file read data 1 (combinational from rf_addr1)
- rf_out2  in  XLEN  register-file read data 2
- wb_valid  in  1  writeback stage writes wb_addr this cycle
- wb_addr  in  AW  writeback destination
- wb_data  in  XLEN  writeback value
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_op  out  6  opcode
- out_funct  out  6  funct field
- out_a  out  XLEN  rs value
- out_b  out  XLEN  rt value
- out_imm  out  XLEN  extended immediate
- out_dest  out  AW  destination register
- out_wen  out  1  instruction writes a register

Behaviour:
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm16=[15:0].
- Decode classes (uses_rs/uses_rt/wen/dest):
  - op 0x00 R-type: 1/1/1/rd.
  - op 0x08-0x0F ALU-imm: 1/0/1/rt.
  - 0x23 lw: 1/0/1/rt.
  - 0x2B sw: 1/1/0/-.
  - 0x04/0x05 beq/bne: 1/1/0/-.
  - 0x02 j and all others: 0/0/0/-.
  - For every instruction with wen=0, out_dest=0.
- Immediate: zero-extended for op 0x0C-0x0E; sign-extended otherwise.
- Register 0 is an ordinary register: no zero forcing, and it is scoreboarded like any other.
- Two holding slots, a decode register (dec_q) and an output register (out_q). FSM state is the pair of valid flags:
  - EMPTY: no slot occupied.
  - DEC: dec only.
  - OUT: out only.
  - BOTH: both occupied.
- rf_addr1/rf_addr2 are driven from dec_q.rs/rt every cycle; they are 0 when dec is empty.
- Hazard: (uses_rs & pend[rs] & !(wb_valid & wb_addr==rs)) | (same for rt).
- adv = dec_valid & !hazard & (!out_valid | out_ready).
- in_ready = !dec_valid | adv. It is combinational; it never depends on in_valid.
- On adv, out_q loads decoded fields. Operand a = (wb_valid & wb_addr==rs) ? wb_data : rf_out1; b likewise with rt.
- Transitions:
  - Accept (in_valid & in_ready) loads dec_q.
  - adv without accept empties dec.
  - out_ready & out_valid without adv empties out.
- Latency: instruction accepted at edge N appears with out_valid=1 after edge N+1 when hazard-free. Throughput is 1/cycle.
- Scoreboard: on adv with wen, pend[dest] is set. On wb_valid, pend[wb_addr] is cleared. If both hit the same index in one cycle, the set wins.
- out_q holds stable while out_valid & !out_ready.
- Stall while hazard persists; dec_q is held and in_ready=0 when dec is full.
- Reset (async, any time, including mid-stall):
  - dec/out valid = 0, pend = 0.
  - out_* = 0, in_ready = 1, rf_addr* = 0.
- Out-of-class opcodes pass through as nops (wen=0); no error flag.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode constants (OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI..OP_LUI, OP_LW, OP_SW).
  - field bit positions.
  - decoded-instruction struct {op, funct, rs, rt, dest, imm, uses_rs, uses_rt, wen}.
- One sub-module, `instr_decode`: purely combinational, instruction in and decoded struct out.
- The FSM, scoreboard and bypass stay in operand_fetch.

Test Plan:
- Reset mid-operation: assert rst_n=0 while BOTH with pend[5]=1 -> immediately out_valid=0 and in_ready=1; after release, pend is all 0 and rs=5 issues without stall.
- Back-to-back independent: addi r3,r1,7 then or r4,r2,r6 with out_ready=1 and regfile r1=1, r2=8, r6=16:
  - cycle 1: out_a=1, out_imm=7, out_dest=3.
  - cycle 2: out_a=8, out_b=16, out_dest=4.
  - no bubbles.
- RAW stall: add r7,r1,r2 then sub r8,r7,r1, with no writeback for 3 cycles -> second instruction stalls and in_ready=0. Then wb_valid, wb_addr=7, wb_data=0x55 -> same cycle adv with out_a=0x55 (bypass), and pend[7] clears.
- Backpressure: out_ready=0 for 4 cycles with 3 instructions offered -> exactly 2 accepted, out_q unchanged. Release -> order is preserved.
- Immediate extension: ori imm 0x8001 -> out_imm=0x00008001; addi imm 0x8001 -> out_imm=0xFFFF8001; sw -> out_wen=0, out_dest=0.
- Set/clear collision: wb_valid clears r9 in the same cycle an add with dest=r9 advances -> pend[9]=1 afterwards. A subsequent rs=r9 reader stalls.
